// File: rtl/mac_seq_ctrl.sv
// Sequencer for an external registered multiply-accumulate cell: streams len operand
// pairs into it, then captures the running sum and presents it on a result handshake.
module mac_seq_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic [31:0]      mac_acc_in,
    input  logic [31:0]      mac_acc_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      res_data_q, res_data_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            res_data_q <= res_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        res_data_d = res_data_q;
        mac_a      = '0;
        mac_b      = '0;
        mac_acc_in = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = len;
                    cnt_d = '0;
                    if (len == '0) begin
                        res_data_d = '0;
                        state_d    = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Gaps recirculate the sum so the cell holds it between beats.
                mac_acc_in = mac_acc_out;
                if (abort) begin
                    state_d = IDLE;
                end else if (op_valid) begin
                    mac_a = op_a;
                    mac_b = op_b;
                    // First beat seeds from zero, so the cell's reset state never matters.
                    if (cnt_q == '0) mac_acc_in = '0;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                mac_acc_in = mac_acc_out;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    res_data_d = mac_acc_out;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign op_ready  = (state_q == RUN);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized bench for mac_seq_ctrl: a behavioural mac cell plus a sum-of-products
// reference for every transaction, with directed abort, reset and zero-length cases.
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a, op_b;
    logic [15:0] mac_a, mac_b;
    logic [31:0] mac_acc_in;
    logic [31:0] mac_acc_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] va [0:255];
    logic [15:0] vb [0:255];

    always #5 clk = ~clk;

    // Registered mac cell, intentionally without reset.
    always_ff @(posedge clk)
        mac_acc_out <= mac_acc_in + {16'b0, mac_a} * {16'b0, mac_b};

    mac_seq_ctrl #(.LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, {31'b0, busy}, 32'd0);
        chk({tag, " op_ready"}, {31'b0, op_ready}, 32'd0);
        chk({tag, " res_valid"}, {31'b0, res_valid}, 32'd0);
        chk({tag, " res_data"}, res_data, 32'd0);
        chk({tag, " mac_ab"}, {mac_a, mac_b}, 32'd0);
        chk({tag, " mac_acc_in"}, mac_acc_in, 32'd0);
    endtask

    // Full transaction using va/vb[0..n-1]; gaps between beats drawn from [mingap,maxgap].
    task automatic run_dot(input int n, input int mingap, input int maxgap, input string tag);
        logic [31:0] exp_sum;
        int gap;
        exp_sum = 32'd0;
        for (int i = 0; i < n; i++) exp_sum += {16'b0, va[i]} * {16'b0, vb[i]};
        start = 1'b1;
        len = 8'(n);
        step();
        start = 1'b0;
        len = 8'($urandom);
        chk({tag, " busy after start"}, {31'b0, busy}, 32'd1);
        if (n > 0) begin
            for (int i = 0; i < n; i++) begin
                gap = $urandom_range(maxgap, mingap);
                repeat (gap) begin
                    op_valid = 1'b0;
                    op_a = 16'($urandom);
                    op_b = 16'($urandom);
                    start = ($urandom_range(0, 3) == 0);
                    step();
                    start = 1'b0;
                end
                op_valid = 1'b1;
                op_a = va[i];
                op_b = vb[i];
                chk({tag, " op_ready"}, {31'b0, op_ready}, 32'd1);
                step();
            end
            op_valid = 1'b0;
            chk({tag, " drain no valid"}, {31'b0, res_valid}, 32'd0);
            chk({tag, " drain op_ready"}, {31'b0, op_ready}, 32'd0);
            step();
        end
        chk({tag, " res_valid"}, {31'b0, res_valid}, 32'd1);
        chk({tag, " res_data"}, res_data, exp_sum);
        chk({tag, " done mac_acc_in"}, mac_acc_in, 32'd0);
        repeat ($urandom_range(0, 3)) begin
            res_ready = 1'b0;
            start = ($urandom_range(0, 1) == 1);
            step();
            start = 1'b0;
            chk({tag, " hold valid"}, {31'b0, res_valid}, 32'd1);
            chk({tag, " hold data"}, res_data, exp_sum);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, " idle after ack"}, {31'b0, busy}, 32'd0);
        chk({tag, " valid after ack"}, {31'b0, res_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0;
        op_valid = 1'b0; op_a = 16'd0; op_b = 16'd0; res_ready = 1'b0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();

        // Back-to-back (3,4),(2,5)
        va[0] = 16'd3; vb[0] = 16'd4; va[1] = 16'd2; vb[1] = 16'd5;
        run_dot(2, 0, 0, "b2b");

        // Two idle cycles between each beat
        va[0] = 16'd1; vb[0] = 16'd1; va[1] = 16'd2; vb[1] = 16'd2; va[2] = 16'd3; vb[2] = 16'd3;
        run_dot(3, 2, 2, "gaps");

        // Zero length: result next cycle, held while res_ready low; stray start/abort ignored
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        chk("len0 valid", {31'b0, res_valid}, 32'd1);
        chk("len0 data", res_data, 32'd0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = 8'd3; abort = (i == 2);
            step();
            chk("len0 hold valid", {31'b0, res_valid}, 32'd1);
            chk("len0 hold data", res_data, 32'd0);
        end
        start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("len0 ack", {31'b0, busy}, 32'd0);

        // abort alone in IDLE does nothing
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle abort", {31'b0, busy}, 32'd0);

        // Modulo-2^32 wrap
        va[0] = 16'hFFFF; vb[0] = 16'hFFFF; va[1] = 16'hFFFF; vb[1] = 16'hFFFF;
        run_dot(2, 0, 1, "wrap");

        // Abort after beat 2, with a beat offered in the abort cycle
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_valid = 1'b1; op_a = 16'(i + 5); op_b = 16'(i + 9);
            step();
        end
        abort = 1'b1; op_a = 16'd100; op_b = 16'd100;
        step();
        abort = 1'b0; op_valid = 1'b0;
        chk("abort idle", {31'b0, busy}, 32'd0);
        repeat (3) begin
            step();
            chk("abort no result", {31'b0, res_valid}, 32'd0);
        end
        va[0] = 16'd7; vb[0] = 16'd6;
        run_dot(1, 0, 0, "after abort");

        // Abort during DRAIN discards the result
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0; op_valid = 1'b1; op_a = 16'd11; op_b = 16'd11;
        step();
        op_valid = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("drain abort idle", {31'b0, busy}, 32'd0);
        chk("drain abort valid", {31'b0, res_valid}, 32'd0);

        // Reset mid-RUN after beat (9,9)
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0; op_valid = 1'b1; op_a = 16'd9; op_b = 16'd9;
        step();
        op_a = 16'd9; op_b = 16'd9;
        #2 rst = 1'b0;
        #1;
        chk_all_zero("mid reset");
        op_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        step();
        va[0] = 16'd2; vb[0] = 16'd3;
        run_dot(1, 0, 0, "after reset");

        // Randomized transactions
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                va[i] = 16'($urandom);
                vb[i] = 16'($urandom);
            end
            run_dot(n, 0, 2, "rand");
        end

        // Maximum length, back-to-back
        for (int i = 0; i < 255; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
        end
        run_dot(255, 0, 0, "max len");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
